// File: rtl/per2apb.sv
`default_nettype none
// ============================================================================
//  Module   : per2apb
//  Purpose  : Peripheral-interconnect (req/gnt/r_valid) slave to APB3 master
//             bridge. One outstanding transfer; every grant yields exactly
//             one response beat.
//  Options  : PER2APB_TIMEOUT_EN - abort an ACCESS phase that waits
//             TIMEOUT_CYCLES cycles without PREADY, answering with error.
//  Revision : 1.0 - initial release
// ============================================================================
module per2apb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    per_slave_req_i,
  input  logic [ADDR_WIDTH-1:0]   per_slave_add_i,
  input  logic                    per_slave_we_i,
  input  logic [DATA_WIDTH-1:0]   per_slave_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] per_slave_be_i,
  output logic                    per_slave_gnt_o,
  output logic                    per_slave_r_valid_o,
  output logic                    per_slave_r_opc_o,
  output logic [DATA_WIDTH-1:0]   per_slave_r_rdata_o,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic                    PWRITE,
  output logic                    PSEL,
  output logic                    PENABLE,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
  logic                  r_pwrite, w_pwrite_nxt;
  logic                  r_psel, w_psel_nxt;
  logic                  r_penable, w_penable_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_opc, w_opc_nxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic                  w_grant;

  // APB3 carries no byte strobes, so the enables are intentionally dropped.
  logic w_unused_be;
  assign w_unused_be = ^per_slave_be_i;

`ifdef PER2APB_TIMEOUT_EN
  // Abort fires in the ACCESS cycle whose stall would bring the count to the limit.
  localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tmo_cnt, w_tmo_cnt_nxt;
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
`endif

  // Grant only from IDLE and never while reset is asserted.
  assign w_grant = per_slave_req_i && (r_state == S_IDLE) && !rst;

  // Next-state and next-value logic for all registered outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;
    w_pwrite_nxt  = r_pwrite;
    w_psel_nxt    = r_psel;
    w_penable_nxt = r_penable;
    w_valid_nxt   = 1'b0;
    w_opc_nxt     = r_opc;
    w_rdata_nxt   = r_rdata;
`ifdef PER2APB_TIMEOUT_EN
    w_tmo_cnt_nxt = r_tmo_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_paddr_nxt   = per_slave_add_i;
          w_pwdata_nxt  = per_slave_wdata_i;
          w_pwrite_nxt  = per_slave_we_i;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = S_ACCESS;
`ifdef PER2APB_TIMEOUT_EN
        w_tmo_cnt_nxt = '0;
`endif
      end
      S_ACCESS: begin
        if (PREADY) begin
          // PREADY takes priority over a simultaneous timeout expiry.
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_opc_nxt     = PSLVERR;
          w_rdata_nxt   = r_pwrite ? '0 : PRDATA;
          w_valid_nxt   = 1'b1;
          w_state_nxt   = S_RESP;
        end
`ifdef PER2APB_TIMEOUT_EN
        else if (r_tmo_cnt == c_tmo_last) begin
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_opc_nxt     = 1'b1;
          w_rdata_nxt   = '0;
          w_valid_nxt   = 1'b1;
          w_state_nxt   = S_RESP;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
        end
`endif
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_valid   <= 1'b0;
      r_opc     <= 1'b0;
      r_rdata   <= '0;
`ifdef PER2APB_TIMEOUT_EN
      r_tmo_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_valid   <= w_valid_nxt;
      r_opc     <= w_opc_nxt;
      r_rdata   <= w_rdata_nxt;
`ifdef PER2APB_TIMEOUT_EN
      r_tmo_cnt <= w_tmo_cnt_nxt;
`endif
    end
  end

  assign per_slave_gnt_o     = w_grant;
  assign per_slave_r_valid_o = r_valid;
  assign per_slave_r_opc_o   = r_opc;
  assign per_slave_r_rdata_o = r_rdata;
  assign PADDR               = r_paddr;
  assign PWDATA              = r_pwdata;
  assign PWRITE              = r_pwrite;
  assign PSEL                = r_psel;
  assign PENABLE             = r_penable;

endmodule
`default_nettype wire

// File: doc/per2apb.md
Name: per2apb

Overview:
- Bridge from the on-chip peripheral interconnect protocol (req/gnt/r_valid, slave side) to an APB3 master port.
- It is the counterpart of the existing APB-to-peripheral bridge: a per-protocol initiator (e.g. debug or core data port) is served by this block, which runs APB transfers onto an APB slave or APB bus segment.
- One outstanding transaction at a time. Every granted request, read or write, produces exactly one response beat.

Parameters:
- ADDR_WIDTH, 32, width of per_slave_add_i and PADDR
- DATA_WIDTH, 32, width of write/read data on both sides
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before abort; only used with PER2APB_TIMEOUT_EN; legal range 1..65535

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- per_slave_req_i  input  1  request valid
- per_slave_add_i  input  ADDR_WIDTH  byte address
- per_slave_we_i  input  1  1 = write, 0 = read
- per_slave_wdata_i  input  DATA_WIDTH  write data
- per_slave_be_i  input  DATA_WIDTH/8  byte enables; ignored, APB3 has no strobe
- per_slave_gnt_o  output  1  request accepted this cycle
- per_slave_r_valid_o  output  1  response beat, one-cycle pulse
- per_slave_r_opc_o  output  1  0 = OK, 1 = error (PSLVERR or timeout)
- per_slave_r_rdata_o  output  DATA_WIDTH  read data
- PADDR  output  ADDR_WIDTH  APB address
- PWDATA  output  DATA_WIDTH  APB write data
- PWRITE  output  1  APB direction
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PRDATA  input  DATA_WIDTH  APB read data
- PREADY  input  1  APB ready
- PSLVERR  input  1  APB error

Behaviour:
- Reset (rst=1 at a clock edge) sets the FSM to IDLE. The following outputs go to 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, r_valid, r_opc, r_rdata, and the timeout counter. gnt_o=0 while rst=1.
- FSM states are IDLE, SETUP, ACCESS, RESP. All APB and response outputs are registered. gnt_o is combinational: gnt_o = req_i && state==IDLE && !rst.
- IDLE:
  - If req_i=1, grant and latch add/we/wdata into PADDR/PWRITE/PWDATA.
  - Set PSEL=1, PENABLE=0, then go to SETUP.
  - Otherwise stay in IDLE; PADDR/PWDATA/PWRITE hold their last values.
- SETUP: lasts one cycle. Set PENABLE=1, then go to ACCESS.
- ACCESS:
  - Hold all APB outputs stable while PREADY=0; wait states are unbounded unless the timeout is enabled.
  - On PREADY=1:
    - Clear PSEL and PENABLE.
    - Capture r_opc=PSLVERR.
    - Capture r_rdata=PRDATA for reads; r_rdata=0 for writes.
    - Go to RESP.
- RESP:
  - r_valid=1 for exactly this one cycle, then go to IDLE.
  - r_opc and r_rdata hold their values until the next response.
  - No grant is given in RESP.
- Latency with zero wait states:
  - Grant at cycle N.
  - SETUP is visible at N+1 (PSEL=1, PENABLE=0).
  - ACCESS is visible at N+2 (PENABLE=1; PREADY sampled).
  - r_valid=1 at N+3.
  - Each wait state adds one cycle.
  - Back-to-back throughput is one transfer per 4 cycles: the next gnt comes no earlier than N+4.
- PSEL=1 && PENABLE=1 is asserted only in ACCESS. PSEL never asserts without a latched request.
- Request-side signals other than req_i are don't-care except in the grant cycle.
- Mid-transfer reset: at the reset edge the FSM returns to IDLE and PSEL/PENABLE drop. No r_valid is issued for the aborted transfer.
- Address and data are passed through unmodified; there is no alignment, masking or decode.

Optional Feature:
- Macro: PER2APB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES with PREADY still 0, the transfer is aborted: PSEL/PENABLE are cleared, r_opc=1, r_rdata=0, and the FSM goes to RESP.
  - If PREADY=1 arrives in the same cycle as expiry, PREADY wins and the normal response is given.
- Not defined: no counter exists, ACCESS waits indefinitely, and TIMEOUT_CYCLES is unused.

Test Plan:
- Read, zero wait: req at 0x1A10_2004, we=0, PREADY=1, PRDATA=0xCAFE_0001 at first ACCESS cycle -> gnt at N; PSEL at N+1; PENABLE at N+2; r_valid at N+3 with rdata=0xCAFE_0001, opc=0.
- Write, 3 wait states: add=0x1A10_7000, wdata=0x0000_00A5, PREADY low for 3 ACCESS cycles -> PADDR/PWDATA/PWRITE=1 stable throughout; r_valid at N+6 with opc=0, rdata=0.
- Error: read with PSLVERR=1 and PREADY=1 -> r_valid with opc=1.
- Back-to-back: req held high for 3 transfers -> gnt at N, N+4, N+8; exactly 3 r_valid pulses; no overlap of PSEL between transfers' addresses.
- Reset mid-ACCESS: rst=1 while PREADY=0 -> PSEL=PENABLE=0 after the edge; no r_valid; next request completes normally.
- Timeout (PER2APB_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - PREADY never asserted -> abort after 4 ACCESS cycles; r_valid with opc=1, rdata=0.
  - PREADY asserted exactly at expiry -> opc=PSLVERR and rdata=PRDATA.
